// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode constants, class/immediate-format
// encodings and the fixed-width part of the decoded bundle. PC and immediate
// are XLEN-wide and therefore travel next to the struct, not inside it.
package rv32_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [3:0] {
        InstNone   = 4'b0000,
        InstLoad   = 4'b0001,
        InstStore  = 4'b0010,
        InstRAlu   = 4'b0011,
        InstIAlu   = 4'b0100,
        InstBranch = 4'b0101,
        InstJal    = 4'b0110,
        InstJalr   = 4'b0111,
        InstLui    = 4'b1000,
        InstAuipc  = 4'b1001,
        InstSystem = 4'b1010,
        InstFence  = 4'b1011
    } inst_type_e;

    typedef enum logic [2:0] {
        ImmI       = 3'b000,
        ImmS       = 3'b001,
        ImmNone    = 3'b010,
        ImmB       = 3'b011,
        ImmU       = 3'b100,
        ImmJ       = 3'b101,
        ImmIllegal = 3'b111
    } imm_type_e;

    typedef struct packed {
        logic [6:0] opcode;
        inst_type_e inst_type;
        imm_type_e  imm_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bus of the decode stage.
//   upstream  : flush, in_valid, in_ready, instruction, in_pc
//   downstream: out_valid, out_ready, out_pc, decoded fields, imm, illegal,
//               illegal_count
// slave = the decode stage, master = its environment.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    import rv32_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    inst_type_e      inst_type;
    imm_type_e       imm_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [15:0]     illegal_count;

    modport slave (
        input  flush, in_valid, instruction, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, inst_type, imm_type,
               rd, rs1, rs2, func3, func7, imm, illegal, illegal_count
    );

    modport master (
        output flush, in_valid, instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, inst_type, imm_type,
               rd, rs1, rs2, func3, func7, imm, illegal, illegal_count
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational field and immediate extraction for one RV32I word.
//   instruction : raw 32-bit word
//   fields      : class, immediate format and register/func fields; fields
//                 absent from the format are 0; illegal set for unknown opcodes
//   imm         : immediate sign-extended from instruction[31] to XLEN
module imm_gen
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instruction,
    output decoded_t        fields,
    output logic [XLEN-1:0] imm
);
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]      f3;

    assign f3    = instruction[14:12];
    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    // Top bit split off so the replication count is never zero at XLEN=32.
    assign imm_u = {{(XLEN-31){instruction[31]}}, instruction[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        fields           = '0;
        fields.opcode    = instruction[6:0];
        fields.inst_type = InstNone;
        fields.imm_type  = ImmIllegal;
        imm              = '0;
        case (instruction[6:0])
            OpLoad, OpJalr, OpSystem, OpFence: begin
                unique case (instruction[6:0])
                    OpLoad:   fields.inst_type = InstLoad;
                    OpJalr:   fields.inst_type = InstJalr;
                    OpSystem: fields.inst_type = InstSystem;
                    default:  fields.inst_type = InstFence;
                endcase
                fields.imm_type = ImmI;
                fields.rd       = instruction[11:7];
                fields.rs1      = instruction[19:15];
                fields.func3    = f3;
                imm             = imm_i;
            end
            OpImm: begin
                fields.inst_type = InstIAlu;
                fields.imm_type  = ImmI;
                fields.rd        = instruction[11:7];
                fields.rs1       = instruction[19:15];
                fields.func3     = f3;
                // Only shifts carry a meaningful func7.
                if (f3 == 3'b001 || f3 == 3'b101) fields.func7 = instruction[31:25];
                imm              = imm_i;
            end
            OpStore: begin
                fields.inst_type = InstStore;
                fields.imm_type  = ImmS;
                fields.rs1       = instruction[19:15];
                fields.rs2       = instruction[24:20];
                fields.func3     = f3;
                imm              = imm_s;
            end
            OpReg: begin
                fields.inst_type = InstRAlu;
                fields.imm_type  = ImmNone;
                fields.rd        = instruction[11:7];
                fields.rs1       = instruction[19:15];
                fields.rs2       = instruction[24:20];
                fields.func3     = f3;
                fields.func7     = instruction[31:25];
            end
            OpBranch: begin
                fields.inst_type = InstBranch;
                fields.imm_type  = ImmB;
                fields.rs1       = instruction[19:15];
                fields.rs2       = instruction[24:20];
                fields.func3     = f3;
                imm              = imm_b;
            end
            OpLui, OpAuipc: begin
                fields.inst_type = (instruction[6:0] == OpLui) ? InstLui : InstAuipc;
                fields.imm_type  = ImmU;
                fields.rd        = instruction[11:7];
                imm              = imm_u;
            end
            OpJal: begin
                fields.inst_type = InstJal;
                fields.imm_type  = ImmJ;
                fields.rd        = instruction[11:7];
                imm              = imm_j;
            end
            default: fields.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of decode_stage_if (input handshake + word/PC,
//              flush, output handshake + decoded bundle, illegal counter)
// SKID_EN=1 adds a second entry so in_ready comes straight from a flop;
// SKID_EN=0 keeps a single output register with a combinational in_ready.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SKID_EN = 1
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);
    decoded_t        raw_fields, dec_fields, out_fields_q, skid_fields_q;
    logic [XLEN-1:0] raw_imm, dec_imm, out_imm_q, skid_imm_q, out_pc_q, skid_pc_q;
    logic            out_valid_q, out_valid_d, skid_full_q, skid_full_d, in_ready_q;
    logic            in_ready, acc, deq, bad;
    logic            load_out_new, load_out_skid, load_skid, count_inc;
    logic [15:0]     illegal_count_q;
    logic [2:0]      f3;
    logic [6:0]      f7;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction(bus.instruction),
        .fields     (raw_fields),
        .imm        (raw_imm)
    );

    assign f3 = bus.instruction[14:12];
    assign f7 = bus.instruction[31:25];

    // Legality check; an illegal word keeps only opcode (and PC) visible.
    always_comb begin
        bad = raw_fields.illegal;
        case (raw_fields.inst_type)
            InstRAlu:   if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
                            bad = 1'b1;
            InstIAlu:   if ((f3 == 3'b001 && f7 != 7'h00) ||
                            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) bad = 1'b1;
            InstLoad:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
            InstStore:  if (f3 > 3'b010) bad = 1'b1;
            InstBranch: if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
            InstJalr:   if (f3 != 3'b000) bad = 1'b1;
            default:    ;
        endcase
        dec_fields = raw_fields;
        dec_imm    = raw_imm;
        if (bad) begin
            dec_fields           = '0;
            dec_fields.opcode    = bus.instruction[6:0];
            dec_fields.inst_type = InstNone;
            dec_fields.imm_type  = ImmIllegal;
            dec_fields.illegal   = 1'b1;
            dec_imm              = '0;
        end
    end

    assign in_ready = (SKID_EN != 0) ? in_ready_q
                                     : (!rst && (!out_valid_q || bus.out_ready));
    assign acc = bus.in_valid && in_ready;
    assign deq = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_full_d   = skid_full_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (!out_valid_q || deq) begin
            // Skid is never full while in_ready is high, so no accept competes here.
            if (skid_full_q) begin
                load_out_skid = 1'b1;
                out_valid_d   = 1'b1;
                skid_full_d   = 1'b0;
            end else begin
                load_out_new = acc;
                out_valid_d  = acc;
            end
        end else if (acc) begin
            load_skid   = 1'b1;
            skid_full_d = 1'b1;
        end
    end

    assign count_inc = acc && !bus.flush && dec_fields.illegal && (illegal_count_q != 16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            skid_full_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            illegal_count_q <= '0;
            out_fields_q    <= '0;
            out_imm_q       <= '0;
            out_pc_q        <= '0;
            skid_fields_q   <= '0;
            skid_imm_q      <= '0;
            skid_pc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
            if (load_out_new) begin
                out_fields_q <= dec_fields;
                out_imm_q    <= dec_imm;
                out_pc_q     <= bus.in_pc;
            end else if (load_out_skid) begin
                out_fields_q <= skid_fields_q;
                out_imm_q    <= skid_imm_q;
                out_pc_q     <= skid_pc_q;
            end
            if (load_skid) begin
                skid_fields_q <= dec_fields;
                skid_imm_q    <= dec_imm;
                skid_pc_q     <= bus.in_pc;
            end
            if (count_inc) illegal_count_q <= illegal_count_q + 16'd1;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_pc_q;
    assign bus.opcode        = out_fields_q.opcode;
    assign bus.inst_type     = out_fields_q.inst_type;
    assign bus.imm_type      = out_fields_q.imm_type;
    assign bus.rd            = out_fields_q.rd;
    assign bus.rs1           = out_fields_q.rs1;
    assign bus.rs2           = out_fields_q.rs2;
    assign bus.func3         = out_fields_q.func3;
    assign bus.func7         = out_fields_q.func7;
    assign bus.imm           = out_imm_q;
    assign bus.illegal       = out_fields_q.illegal;
    assign bus.illegal_count = illegal_count_q;
endmodule
